// File: rtl/dff_pkg.sv
// -----------------------------------------------------------------------------
// dff_pkg
// Purpose : shared defaults and the next-state helper for the dff storage
//           register family.
// Contents: DFF_DEFAULT_WIDTH  - default number of stored bits (1)
//           DFF_DEFAULT_RESET  - default per-bit reset value (0)
//           dff_cell_next()    - load-or-hold selection for one stored bit
// -----------------------------------------------------------------------------
package dff_pkg;

    localparam int   DFF_DEFAULT_WIDTH = 1;
    localparam logic DFF_DEFAULT_RESET = 1'b0;

    // Returns the sampled input when loading, otherwise the current value.
    // The input is passed through untouched, so X/Z on it is stored as-is.
    function automatic logic dff_cell_next(
        input logic cur_val,
        input logic din,
        input logic load
    );
        return load ? din : cur_val;
    endfunction

endpackage : dff_pkg

// File: rtl/dff_cell.sv
// -----------------------------------------------------------------------------
// dff_cell
// Purpose : one-bit positive-edge storage element with asynchronous,
//           active-high reset to a per-bit reset value.
// Ports   : clk     in  1  rising-edge clock
//           reset   in  1  asynchronous active-high reset
//           rst_val in  1  value loaded while reset is high
//           d       in  1  data sampled on the rising clk edge
//           en      in  1  clock enable (only with DFF_CLOCK_ENABLE_EN)
//           q       out 1  stored bit
// Macro   : DFF_CLOCK_ENABLE_EN adds the en port; without it the cell loads
//           on every rising edge.
// -----------------------------------------------------------------------------
module dff_cell
    import dff_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
`ifdef DFF_CLOCK_ENABLE_EN
    input  logic en,
`endif
    output logic q
);

    logic q_q;
    logic q_d;

    // Next-state selection: load d, or hold when the enable is low.
    always_comb begin
        q_d = q_q;
`ifdef DFF_CLOCK_ENABLE_EN
        q_d = dff_cell_next(q_q, d, en);
`else
        q_d = dff_cell_next(q_q, d, 1'b1);
`endif
    end

    // Storage bit: reset forces rst_val at once and masks clk edges while high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : dff_cell

// File: rtl/dff.sv
// -----------------------------------------------------------------------------
// dff
// Purpose : WIDTH-bit positive-edge D register with true and complemented
//           outputs, built from independent one-bit dff_cell instances.
// Params  : WIDTH        number of stored bits (>= 1)
//           RESET_VALUE  value held in q while reset is high
// Ports   : clk    in  1      rising-edge clock
//           reset  in  1      asynchronous active-high reset
//           d      in  WIDTH  data sampled on the rising clk edge
//           en     in  1      clock enable (only with DFF_CLOCK_ENABLE_EN)
//           q      out WIDTH  registered data
//           q_bar  out WIDTH  bitwise complement of q
// Macro   : DFF_CLOCK_ENABLE_EN adds the en port; the default build exposes
//           clk/reset/d/q/q_bar only and loads on every rising edge.
// -----------------------------------------------------------------------------
module dff
    import dff_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_DEFAULT_RESET}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
`ifdef DFF_CLOCK_ENABLE_EN
    input  logic             en,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    logic [WIDTH-1:0] q_s;

    // One storage cell per bit; bits share clock, reset and enable only.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        dff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VALUE[i]),
            .d       (d[i]),
`ifdef DFF_CLOCK_ENABLE_EN
            .en      (en),
`endif
            .q       (q_s[i])
        );
    end

    // q_bar is derived from the same storage, so it tracks q even in reset.
    assign q     = q_s;
    assign q_bar = ~q_s;

endmodule : dff

// File: tb/tb_dff.sv
// -----------------------------------------------------------------------------
// tb_dff
// Bench for dff: a default 1-bit instance and an 8-bit instance with reset
// value 8'hA5. A directed timeline is followed by randomized cycles; every
// expected value is pushed into a scoreboard queue and a separate monitor
// compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_dff;
    import dff_pkg::*;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk;
    logic       r1;
    logic       r8;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic       q1_bar;
    logic [7:0] q8;
    logic [7:0] q8_bar;
`ifdef DFF_CLOCK_ENABLE_EN
    logic       en;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        bit         wide;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;

    dff u_dut1 (
        .clk   (clk),
        .reset (r1),
        .d     (d1),
`ifdef DFF_CLOCK_ENABLE_EN
        .en    (en),
`endif
        .q     (q1),
        .q_bar (q1_bar)
    );

    dff #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .clk   (clk),
        .reset (r8),
        .d     (d8),
`ifdef DFF_CLOCK_ENABLE_EN
        .en    (en),
`endif
        .q     (q8),
        .q_bar (q8_bar)
    );

    // Queue an expectation and wake the monitor.
    task automatic push_exp(input string nm, input bit wide, input logic [7:0] v);
        exp_t e;
        e.name = nm;
        e.wide = wide;
        e.exp  = v;
        sb_q.push_back(e);
        -> sample_ev;
    endtask

    task automatic wait_until(input longint t);
        if ($time < t) #(t - $time);
    endtask

    // Reference behaviour of one register at a rising edge.
    function automatic logic [7:0] edge_model(input logic [7:0] cur, input logic [7:0] din,
                                              input bit rst_hi, input bit en_v);
        if (rst_hi) return cur;
        if (en_v)   return din;
        return cur;
    endfunction

    // Monitor: drains the scoreboard each time it is woken.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.wide) begin
                    checks++;
                    if (q8 !== e.exp) begin
                        errors++;
                        $display("FAIL %s q8: got %h expected %h at %0t", e.name, q8, e.exp, $time);
                    end
                    checks++;
                    if (q8_bar !== ~e.exp) begin
                        errors++;
                        $display("FAIL %s q8_bar: got %h expected %h at %0t", e.name, q8_bar, ~e.exp, $time);
                    end
                end else begin
                    checks++;
                    if (q1 !== e.exp[0]) begin
                        errors++;
                        $display("FAIL %s q1: got %b expected %b at %0t", e.name, q1, e.exp[0], $time);
                    end
                    checks++;
                    if (q1_bar !== ~e.exp[0]) begin
                        errors++;
                        $display("FAIL %s q1_bar: got %b expected %b at %0t", e.name, q1_bar, ~e.exp[0], $time);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Stimulus: directed timeline, then randomized cycles.
    initial begin
        logic       m1;
        logic [7:0] m8;
        bit         do_r1, do_r8, hold1, hold8, en_v;

        clk = 1'b0; r1 = 1'b1; r8 = 1'b1; d1 = 1'b0; d8 = 8'h3C;
`ifdef DFF_CLOCK_ENABLE_EN
        en  = 1'b1;
`endif
        en_v = 1'b1;

        wait_until(1);   push_exp("reset_no_clk", 1'b0, 8'h00);
                         push_exp("reset_w8",     1'b1, RV8);
        wait_until(5);   r1 = 1'b0; r8 = 1'b0;
        wait_until(15);  d1 = 1'b1;
        wait_until(20);  push_exp("d_no_edge", 1'b0, 8'h00);
        wait_until(25);  clk = 1'b1;
        wait_until(26);  push_exp("first_rise", 1'b0, 8'h01);
                         push_exp("w8_load",    1'b1, 8'h3C);
        wait_until(30);  d1 = 1'b0;
        wait_until(40);  push_exp("d_while_high", 1'b0, 8'h01);
        wait_until(50);  clk = 1'b0;
        wait_until(55);  push_exp("falling_edge", 1'b0, 8'h01);
        wait_until(60);  d1 = 1'b1;
        wait_until(65);  push_exp("pulse_low", 1'b0, 8'h01);
        wait_until(70);  d1 = 1'b0;
        wait_until(72);  push_exp("pulse_end", 1'b0, 8'h01);
        wait_until(75);  clk = 1'b1;
        wait_until(76);  push_exp("rise_d0", 1'b0, 8'h00);
        wait_until(90);  d1 = 1'b1;
        wait_until(95);  push_exp("d1_while_high", 1'b0, 8'h00);
        wait_until(100); clk = 1'b0;
        wait_until(105); d1 = 1'b0;
        wait_until(110); clk = 1'b1;
        wait_until(111); push_exp("rise_d0_again", 1'b0, 8'h00);
        wait_until(120); clk = 1'b0;
        wait_until(125); d1 = 1'b1;
        wait_until(130); clk = 1'b1;
        wait_until(131); push_exp("set_one", 1'b0, 8'h01);
        wait_until(140); clk = 1'b0;
        wait_until(145); r1 = 1'b1;
        wait_until(146); push_exp("midrun_reset", 1'b0, 8'h00);
        wait_until(148); r1 = 1'b0;
        wait_until(149); push_exp("after_pulse", 1'b0, 8'h00);
        wait_until(150); clk = 1'b1;
        wait_until(151); push_exp("reload_after_rst", 1'b0, 8'h01);
        wait_until(160); clk = 1'b0;
        wait_until(165); r1 = 1'b1;
        wait_until(170); clk = 1'b1;
        wait_until(171); push_exp("edge_in_reset", 1'b0, 8'h00);
        wait_until(172); r1 = 1'b0;
        wait_until(175); push_exp("released_no_edge", 1'b0, 8'h00);
        wait_until(180); clk = 1'b0;
        wait_until(190); clk = 1'b1;
        wait_until(191); push_exp("first_edge_after_rel", 1'b0, 8'h01);
        wait_until(200); clk = 1'b0;
`ifdef DFF_CLOCK_ENABLE_EN
        en = 1'b0; d8 = 8'hFF;
        wait_until(210); clk = 1'b1;
        wait_until(211); push_exp("en0_hold", 1'b1, 8'h3C);
        wait_until(220); clk = 1'b0; en = 1'b1;
        wait_until(230); clk = 1'b1;
        wait_until(231); push_exp("en1_load", 1'b1, 8'hFF);
        wait_until(240); clk = 1'b0;
        m8 = 8'hFF;
`else
        m8 = 8'h3C;
`endif
        m1 = 1'b1;
        wait_until(250);

        for (int i = 0; i < 300; i++) begin
            d1 = 1'($urandom_range(0, 1));
            d8 = 8'($urandom_range(0, 255));
`ifdef DFF_CLOCK_ENABLE_EN
            en   = 1'($urandom_range(0, 3) != 0);
            en_v = en;
`endif
            do_r1 = ($urandom_range(0, 7) == 0);
            do_r8 = ($urandom_range(0, 7) == 0);
            hold1 = do_r1 && ($urandom_range(0, 1) == 1);
            hold8 = do_r8 && ($urandom_range(0, 1) == 1);
            #1;
            if (do_r1) r1 = 1'b1;
            if (do_r8) r8 = 1'b1;
            #1;
            if (do_r1) begin m1 = 1'b0; push_exp("rnd_rst1", 1'b0, {7'h00, m1}); end
            if (do_r8) begin m8 = RV8;  push_exp("rnd_rst8", 1'b1, m8); end
            #1;
            if (!hold1) r1 = 1'b0;
            if (!hold8) r8 = 1'b0;
            #2;
            clk = 1'b1;
            m1 = edge_model({7'h00, m1}, {7'h00, d1}, hold1, en_v) != 8'h00;
            m8 = edge_model(m8, d8, hold8, en_v);
            #1;
            push_exp("rnd_edge1", 1'b0, {7'h00, m1});
            push_exp("rnd_edge8", 1'b1, m8);
            r1 = 1'b0; r8 = 1'b0;
            #1;
            d1 = ~d1; d8 = ~d8;
            #1;
            push_exp("rnd_hold1", 1'b0, {7'h00, m1});
            push_exp("rnd_hold8", 1'b1, m8);
            #2;
            clk = 1'b0;
        end

        #1;
        -> sample_ev;
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dff
